// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the parametrised sequence detector.
// Reset configuration reproduces the legacy fixed 1101 overlapping detector.
package seq_det_pkg;

  localparam int SEQDET_MAX_W = 32;

  localparam int SEQDET_RST_PAT = 'b1101;
  localparam int SEQDET_RST_LEN = 4;
  localparam bit SEQDET_RST_OVL = 1'b1;

  typedef struct packed {
    logic [SEQDET_MAX_W-1:0] pattern;
    logic [7:0]              len;
    logic                    overlap;
  } seq_det_cfg_t;

  localparam seq_det_cfg_t SEQDET_RST_CFG = '{
    pattern: SEQDET_MAX_W'(SEQDET_RST_PAT),
    len:     8'(SEQDET_RST_LEN),
    overlap: SEQDET_RST_OVL
  };

  function automatic int unsigned seq_det_clamp(
    input int unsigned len,
    input int unsigned max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter: holds at all-ones, sync clear wins over inc.
// Used for the optional match statistics.
module seq_det_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = &cnt;

  // count up until all-ones, then hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial pattern detector with one-cycle match pulse.
// Define SEQDET_CNT_EN to add the saturating match counter outputs.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             data_vld,
  input  logic             data_in,
  output logic             match
`ifdef SEQDET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
`endif
);

  localparam logic [PAT_W-1:0] RST_PAT =
    PAT_W'(SEQDET_RST_CFG.pattern);
  localparam logic [LEN_W-1:0] RST_LEN =
    LEN_W'(seq_det_clamp(32'(SEQDET_RST_CFG.len), PAT_W));
  localparam logic RST_OVL = SEQDET_RST_CFG.overlap;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             ovl_q, ovl_n;
  logic [PAT_W-1:0] sr_q, sr_n;
  logic [LEN_W-1:0] fill_q, fill_n;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] win, mask;
  logic             pat_ok, fill_ok, hit;
  logic             match_n;

  // window compare: low len_q bits of history+new bit against pattern
  always_comb begin
    mask = '0;
    win  = {sr_q[PAT_W-2:0], data_in};
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    pat_ok   = (((win ^ pat_q) & mask) == '0);
    fill_ok  = (({1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1})
                >= {1'b0, len_q});
    hit      = (len_q != '0) && fill_ok && pat_ok;
    fill_inc = (fill_q == FILL_MAX) ? fill_q
                                    : fill_q + LEN_W'(1);
  end

  // next state: clr beats cfg_we beats data
  always_comb begin
    pat_n   = pat_q;
    len_n   = len_q;
    ovl_n   = ovl_q;
    sr_n    = sr_q;
    fill_n  = fill_q;
    match_n = 1'b0;
    if (clr) begin
      sr_n   = '0;
      fill_n = '0;
    end else if (cfg_we) begin
      pat_n  = cfg_pattern;
      len_n  = LEN_W'(seq_det_clamp(32'(cfg_len), PAT_W));
      ovl_n  = cfg_overlap;
      sr_n   = '0;
      fill_n = '0;
    end else if (data_vld) begin
      sr_n    = win;
      match_n = hit;
      fill_n  = (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  // configuration, history and match pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q  <= RST_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= RST_OVL;
      sr_q   <= '0;
      fill_q <= '0;
      match  <= 1'b0;
    end else begin
      pat_q  <= pat_n;
      len_q  <= len_n;
      ovl_q  <= ovl_n;
      sr_q   <= sr_n;
      fill_q <= fill_n;
      match  <= match_n;
    end
  end

`ifdef SEQDET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (match_n),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param.
// Counter checks are active when SEQDET_CNT_EN is defined.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       data_vld;
  logic       data_in;
  logic       match;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

`ifdef SEQDET_CNT_EN
  logic [15:0] match_cnt;
  logic        cnt_sat;
  logic        match2;
  logic [1:0]  match_cnt2;
  logic        cnt_sat2;

  seq_detector_param #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_vld(data_vld),
    .data_in(data_in), .match(match),
    .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .clr(clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_vld(data_vld),
    .data_in(data_in), .match(match2),
    .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );
`else
  seq_detector_param #(.PAT_W(8), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .data_vld(data_vld),
    .data_in(data_in), .match(match)
  );
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic exp,
                      input string tag);
    data_vld = 1'b1;
    data_in  = b;
    @(posedge clk);
    #1;
    chk(tag, 32'(match), 32'(exp));
    data_vld = 1'b0;
  endtask

  task automatic gap();
    data_vld = 1'b0;
    data_in  = 1'b1;
    @(posedge clk);
    #1;
    chk("gap", 32'(match), 32'd0);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    data_vld    = 1'b1;
    data_in     = 1'b1;
    @(posedge clk);
    #1;
    chk("cfg_we", 32'(match), 32'd0);
    cfg_we   = 1'b0;
    data_vld = 1'b0;
  endtask

  task automatic rst_pulse();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", 32'(match), 32'd0);
`ifdef SEQDET_CNT_EN
    chk("async_rst_cnt", 32'(match_cnt), 32'd0);
`endif
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] s1;
    logic [13:0] e_ovl;
    logic [13:0] e_nov;
    logic [7:0]  a5;

    s1    = 14'b11101101011010;
    e_ovl = 14'b00001001000010;
    e_nov = 14'b00001000000010;
    a5    = 8'hA5;

    rstn = 1'b0; clr = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    data_vld = 1'b0; data_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_match", 32'(match), 32'd0);
`ifdef SEQDET_CNT_EN
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
`endif
    rstn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 13; i >= 0; i--)
      send(s1[i], e_ovl[i], "ovl_stream");
`ifdef SEQDET_CNT_EN
    chk("ovl_cnt", 32'(match_cnt), 32'd3);
    chk("cnt2_sat_val", 32'(match_cnt2), 32'd3);
    chk("cnt2_sat_flag", 32'(cnt_sat2), 32'd1);
`endif

    cfg(8'h0D, 4'd4, 1'b0);
    for (int i = 13; i >= 0; i--)
      send(s1[i], e_nov[i], "nov_stream");
`ifdef SEQDET_CNT_EN
    chk("nov_cnt_total", 32'(match_cnt), 32'd5);
    chk("nov_cnt_nosat", 32'(cnt_sat), 32'd0);
    chk("cnt2_stuck", 32'(match_cnt2), 32'd3);
    chk("cnt2_still_sat", 32'(cnt_sat2), 32'd1);
`endif

    clr = 1'b1;
    data_vld = 1'b1;
    data_in = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_match", 32'(match), 32'd0);
`ifdef SEQDET_CNT_EN
    chk("clr_cnt", 32'(match_cnt), 32'd0);
    chk("clr_cnt2", 32'(match_cnt2), 32'd0);
    chk("clr_sat2", 32'(cnt_sat2), 32'd0);
`endif
    clr = 1'b0;
    data_vld = 1'b0;

    cfg(8'hA5, 4'd8, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      send(a5[i], (i == 0), "a5_gapped");
      gap();
    end

    cfg(8'hA5, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--)
      send(a5[i], (i == 0), "len_clamp");

    cfg(8'h01, 4'd1, 1'b1);
    send(1'b1, 1'b1, "len1_a");
    send(1'b1, 1'b1, "len1_b");
    send(1'b1, 1'b1, "len1_c");
    send(1'b0, 1'b0, "len1_zero");

    cfg(8'hFF, 4'd0, 1'b1);
    send(1'b1, 1'b0, "len0_a");
    send(1'b1, 1'b0, "len0_b");
    send(1'b0, 1'b0, "len0_c");
    send(1'b1, 1'b0, "len0_d");

    cfg(8'h0D, 4'd4, 1'b1);
    send(1'b1, 1'b0, "mid_a");
    send(1'b1, 1'b0, "mid_b");
    send(1'b0, 1'b0, "mid_c");
    cfg(8'h0D, 4'd4, 1'b1);
    send(1'b1, 1'b0, "mid_after_cfg");
    send(1'b1, 1'b0, "fresh_b");
    send(1'b0, 1'b0, "fresh_c");
    send(1'b1, 1'b1, "fresh_hit");

    rst_pulse();
    send(1'b1, 1'b0, "rst_a");
    send(1'b1, 1'b0, "rst_b");
    send(1'b0, 1'b0, "rst_c");
    rst_pulse();
    send(1'b1, 1'b0, "rst_mid_pat");
    send(1'b1, 1'b0, "post_b");
    send(1'b0, 1'b0, "post_c");
    send(1'b1, 1'b1, "post_hit");
`ifdef SEQDET_CNT_EN
    chk("post_cnt", 32'(match_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
